// File: rtl/piso_tx_if.sv
// Load handshake and serial output bundle for piso_tx.
// The master drives words in and watches the serial side; the slave is the transmitter.
interface piso_tx_if #(
  parameter int WIDTH = 4
);
  logic             load_valid;
  logic [WIDTH-1:0] data_in;
  logic             load_ready;
  logic             out;
  logic             out_valid;
  logic             done;

  modport master (
    output load_valid,
    output data_in,
    input  load_ready,
    input  out,
    input  out_valid,
    input  done
  );

  modport slave (
    input  load_valid,
    input  data_in,
    output load_ready,
    output out,
    output out_valid,
    output done
  );
endinterface

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: accepts a word on a valid/ready load and
// streams it one bit per clock, reloading on the last bit so words run back to back.
module piso_tx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_LVL  = 1'b0
) (
  input  logic     clk,
  input  logic     rst,
  piso_tx_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;
  logic             last_bit;
  logic             accept;

  function automatic logic first_bit(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  // Move the next bit to the transmit end; the vacated position fills with 0.
  function automatic logic [WIDTH-1:0] shift_sr(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
  endfunction

  assign last_bit = (state == SHIFT) && (cnt == LAST_CNT);

  always_comb begin
    state_nx       = state;
    bus.load_ready = (state == IDLE) || last_bit;
    accept         = bus.load_valid && bus.load_ready;
    case (state)
      IDLE:    if (accept) state_nx = SHIFT;
      SHIFT:   if (last_bit && !accept) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr            <= '0;
      cnt           <= '0;
      bus.out       <= IDLE_LVL;
      bus.out_valid <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      case (state)
        SHIFT: begin
          bus.out       <= first_bit(sr);
          bus.out_valid <= 1'b1;
          bus.done      <= last_bit;
          if (accept) begin
            sr  <= bus.data_in;
            cnt <= '0;
          end else begin
            sr  <= shift_sr(sr);
            cnt <= last_bit ? '0 : cnt + CW'(1);
          end
        end
        default: begin
          bus.out       <= IDLE_LVL;
          bus.out_valid <= 1'b0;
          bus.done      <= 1'b0;
          if (accept) begin
            sr  <= bus.data_in;
            cnt <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Scoreboard bench for piso_tx: an MSB-first/idle-0 instance with a loopback
// receiver and an LSB-first/idle-1 instance, both driven by directed then random words.
module tb_piso_tx;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  piso_tx_if #(.WIDTH(W)) bus_a ();
  piso_tx_if #(.WIDTH(W)) bus_b ();

  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LVL(1'b0)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LVL(1'b1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  logic         lv  [2];
  logic [W-1:0] din [2];
  logic         rdy [2];
  logic         ov  [2];
  logic         o   [2];
  logic         dn  [2];

  assign bus_a.load_valid = lv[0];
  assign bus_a.data_in    = din[0];
  assign bus_b.load_valid = lv[1];
  assign bus_b.data_in    = din[1];
  assign rdy[0] = bus_a.load_ready;
  assign rdy[1] = bus_b.load_ready;
  assign ov[0]  = bus_a.out_valid;
  assign ov[1]  = bus_b.out_valid;
  assign o[0]   = bus_a.out;
  assign o[1]   = bus_b.out;
  assign dn[0]  = bus_a.done;
  assign dn[1]  = bus_b.done;

  typedef struct {
    bit           b;
    bit           last;
    logic [W-1:0] word;
  } ent_t;

  // Bits of accepted words not yet driven, and the bit expected on out this cycle.
  ent_t unsent [2][$];
  ent_t cur    [2];
  bit   cur_v  [2];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic bit msb_first(input int d);
    return (d == 0);
  endfunction

  function automatic bit idle_lvl(input int d);
    return (d == 1);
  endfunction

  task automatic chk(input string nm, input int d, input logic [W-1:0] act, input logic [W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s[dut%0d] @%0t: got %0h, required %0h", nm, d, $time, act, req);
    end
  endtask

  // Reference: a word is a queue of bits; the transmitter can take a word whenever
  // at most one of the current word's bits is still waiting, and emits one bit per edge.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        unsent[d].delete();
        cur_v[d] = 1'b0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        bit   acc;
        ent_t e;
        acc = lv[d] && (unsent[d].size() <= 1);
        cur_v[d] = (unsent[d].size() > 0);
        if (cur_v[d]) cur[d] = unsent[d].pop_front();
        if (acc) begin
          for (int k = 0; k < W; k++) begin
            e.b    = msb_first(d) ? din[d][W-1-k] : din[d][k];
            e.last = (k == W - 1);
            e.word = din[d];
            unsent[d].push_back(e);
          end
        end
      end
    end
  end

  // Receiver on dut_a: shifts each serial bit into its LSB.
  logic [W-1:0] rx = '0;
  always @(posedge clk) rx <= {rx[W-2:0], bus_a.out};

  bit           lb_pend = 1'b0;
  logic [W-1:0] lb_word = '0;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      chk("load_ready", d, rdy[d], (unsent[d].size() <= 1));
      chk("out_valid", d, ov[d], cur_v[d]);
      chk("out", d, o[d], cur_v[d] ? cur[d].b : idle_lvl(d));
      chk("done", d, dn[d], cur_v[d] && cur[d].last);
    end
    if (lb_pend && rst) chk("loopback", 0, rx, lb_word);
    lb_pend = rst && cur_v[0] && cur[0].last;
    lb_word = cur[0].word;
  end

  task automatic cyc(input logic v0, input logic [W-1:0] d0, input logic v1, input logic [W-1:0] d1);
    @(posedge clk);
    #2;
    lv[0]  = v0;
    din[0] = d0;
    lv[1]  = v1;
    din[1] = d1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'h0, 1'b0, 4'h0);
  endtask

  initial begin
    lv[0] = 1'b0; lv[1] = 1'b0;
    din[0] = '0;  din[1] = '0;
    #1 rst = 1'b0;
    #1;
    chk("rst_out", 0, bus_a.out, 1'b0);
    chk("rst_out", 1, bus_b.out, 1'b1);
    chk("rst_ready", 0, bus_a.load_ready, 1'b1);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;

    // Single word on A, LSB-first single word on B.
    cyc(1'b1, 4'b1011, 1'b1, 4'b0001);
    idle(7);

    // Back-to-back: second word taken on the last-bit edge of the first.
    cyc(1'b1, 4'b1011, 1'b0, 4'h0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 4'b0110, 1'b0, 4'h0);
    idle(7);

    // Load offered mid-word is held off until the last bit.
    cyc(1'b1, 4'b1100, 1'b0, 4'h0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 4'b0011, 1'b0, 4'h0);
    idle(7);

    // Asynchronous reset during bit 2 of 4'b1111.
    cyc(1'b1, 4'b1111, 1'b1, 4'b1111);
    idle(3);
    #1 rst = 1'b0;
    #1;
    chk("rst_mid_out", 0, bus_a.out, 1'b0);
    chk("rst_mid_valid", 0, bus_a.out_valid, 1'b0);
    chk("rst_mid_done", 0, bus_a.done, 1'b0);
    chk("rst_mid_out", 1, bus_b.out, 1'b1);
    chk("rst_mid_valid", 1, bus_b.out_valid, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    cyc(1'b1, 4'b1001, 1'b0, 4'h0);
    idle(7);

    // Random traffic with occasional asynchronous resets.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 3) != 0), W'($urandom), ($urandom_range(0, 2) != 0), W'($urandom));
      if ($urandom_range(0, 79) == 0) begin
        #1 rst = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
      end
    end
    idle(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
